// File: rtl/rf_pkg.sv
// Shared widths, types and helpers for the rename-aware architectural register file.
package rf_pkg;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int AW    = $clog2(NREG);
  localparam int TAG_W = 4;

  typedef logic [AW-1:0]    reg_addr_t;
  typedef logic [TAG_W-1:0] rob_tag_t;
  typedef logic [XLEN-1:0]  xdata_t;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + (AW+1)'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/rf_read_port.sv
// One operand lookup: stored entry plus same-cycle commit bypass (highest matching port wins).
module rf_read_port
  import rf_pkg::*;
#(
  parameter int NCM = 2
) (
  input  logic                       rdy_i,
  input  logic [AW-1:0]              addr_i,
  input  logic                       ent_busy_i,
  input  logic [TAG_W-1:0]           ent_tag_i,
  input  logic [XLEN-1:0]            ent_data_i,
  input  logic [NCM-1:0]             cm_vld_i,
  input  logic [NCM-1:0][AW-1:0]     cm_rd_i,
  input  logic [NCM-1:0][TAG_W-1:0]  cm_tag_i,
  input  logic [NCM-1:0][XLEN-1:0]   cm_data_i,
  output logic                       busy_o,
  output logic [TAG_W-1:0]           tag_o,
  output logic [XLEN-1:0]            data_o
);
  always_comb begin
    busy_o = ent_busy_i;
    tag_o  = ent_tag_i;
    data_o = ent_data_i;
    // A commit only bypasses if it will actually retire this cycle (rdy high).
    for (int p = 0; p < NCM; p++) begin
      if (rdy_i && ent_busy_i && cm_vld_i[p] && cm_rd_i[p] == addr_i &&
          cm_tag_i[p] == ent_tag_i) begin
        busy_o = 1'b0;
        data_o = cm_data_i[p];
      end
    end
    if (addr_i == '0) begin
      busy_o = 1'b0;
      tag_o  = '0;
      data_o = '0;
    end
  end
endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register busy/ROB-tag rename status,
// tag-matched commit clear, commit bypass on reads and global flush.
module rename_reg_file
  import rf_pkg::*;
#(
  parameter int NRD = 2,
  parameter int NCM = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic                       iss_vld,
  input  logic [AW-1:0]              iss_rd,
  input  logic [TAG_W-1:0]           iss_tag,
  input  logic [NCM-1:0]             cm_vld,
  input  logic [NCM-1:0][AW-1:0]     cm_rd,
  input  logic [NCM-1:0][TAG_W-1:0]  cm_tag,
  input  logic [NCM-1:0][XLEN-1:0]   cm_data,
  input  logic [NRD-1:0][AW-1:0]     rd_addr,
  output logic [NRD-1:0]             rd_busy,
  output logic [NRD-1:0][TAG_W-1:0]  rd_tag,
  output logic [NRD-1:0][XLEN-1:0]   rd_data,
  output logic [AW:0]                busy_cnt
);
  xdata_t   [NREG-1:0] data_q, data_d;
  rob_tag_t [NREG-1:0] tag_q, tag_d;
  logic     [NREG-1:0] busy_q, busy_d;
  logic     [AW:0]     busy_cnt_q;

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (rdy_in) begin
      for (int p = 0; p < NCM; p++)
        if (cm_vld[p] && cm_rd[p] != '0) data_d[cm_rd[p]] = cm_data[p];
      // Clear compares against the pre-edge tag, so a stale commit leaves busy set.
      for (int p = 0; p < NCM; p++)
        if (cm_vld[p] && cm_rd[p] != '0 && busy_q[cm_rd[p]] && tag_q[cm_rd[p]] == cm_tag[p])
          busy_d[cm_rd[p]] = 1'b0;
      if (flush_in) begin
        busy_d = '0;
      end else if (iss_vld && iss_rd != '0) begin
        busy_d[iss_rd] = 1'b1;
        tag_d[iss_rd]  = iss_tag;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_q     <= '0;
      tag_q      <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      busy_cnt_q <= popcount(busy_d);
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    rf_read_port #(.NCM(NCM)) u_rd (
      .rdy_i     (rdy_in),
      .addr_i    (rd_addr[r]),
      .ent_busy_i(busy_q[rd_addr[r]]),
      .ent_tag_i (tag_q[rd_addr[r]]),
      .ent_data_i(data_q[rd_addr[r]]),
      .cm_vld_i  (cm_vld),
      .cm_rd_i   (cm_rd),
      .cm_tag_i  (cm_tag),
      .cm_data_i (cm_data),
      .busy_o    (rd_busy[r]),
      .tag_o     (rd_tag[r]),
      .data_o    (rd_data[r])
    );
  end
endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench for rename_reg_file: reset, rename/commit, stale tags, priorities, flush, x0, stall.
module tb_rename_reg_file;
  import rf_pkg::*;
  localparam int NRD = 2;
  localparam int NCM = 2;

  logic                       clk_in = 1'b0;
  logic                       rst_n_in, rdy_in, flush_in, iss_vld;
  logic [AW-1:0]              iss_rd;
  logic [TAG_W-1:0]           iss_tag;
  logic [NCM-1:0]             cm_vld;
  logic [NCM-1:0][AW-1:0]     cm_rd;
  logic [NCM-1:0][TAG_W-1:0]  cm_tag;
  logic [NCM-1:0][XLEN-1:0]   cm_data;
  logic [NRD-1:0][AW-1:0]     rd_addr;
  logic [NRD-1:0]             rd_busy;
  logic [NRD-1:0][TAG_W-1:0]  rd_tag;
  logic [NRD-1:0][XLEN-1:0]   rd_data;
  logic [AW:0]                busy_cnt;

  int tests = 0;
  int fails = 0;

  rename_reg_file #(.NRD(NRD), .NCM(NCM)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .iss_vld(iss_vld), .iss_rd(iss_rd), .iss_tag(iss_tag),
    .cm_vld(cm_vld), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
    .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_tag(rd_tag), .rd_data(rd_data),
    .busy_cnt(busy_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    flush_in = 0; iss_vld = 0; iss_rd = '0; iss_tag = '0;
    cm_vld = '0; cm_rd = '0; cm_tag = '0; cm_data = '0;
  endtask

  task automatic issue(input int rd, input int tag);
    idle();
    iss_vld = 1; iss_rd = AW'(rd); iss_tag = TAG_W'(tag);
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n_in = 0; rdy_in = 1; idle(); rd_addr = '0;
    #12;
    rd_addr[0] = 5; rd_addr[1] = 5; #1;
    tests++; if (rd_busy !== 2'b00) begin fails++; $display("FAIL reset_busy got %b want 00", rd_busy); end
    tests++; if (rd_data[0] !== 0 || rd_data[1] !== 0) begin fails++; $display("FAIL reset_data got %h/%h want 0", rd_data[0], rd_data[1]); end
    tests++; if (rd_tag[0] !== 0 || rd_tag[1] !== 0) begin fails++; $display("FAIL reset_tag got %0d/%0d want 0", rd_tag[0], rd_tag[1]); end
    tests++; if (busy_cnt !== 0) begin fails++; $display("FAIL reset_cnt got %0d want 0", busy_cnt); end
    @(negedge clk_in); rst_n_in = 1; tick();
  endtask

  task automatic test_issue_commit();
    issue(5, 3);
    rd_addr[0] = 5; #1;
    tests++; if (rd_busy[0] !== 1 || rd_tag[0] !== 3) begin fails++; $display("FAIL ic_busy got busy=%b tag=%0d want 1/3", rd_busy[0], rd_tag[0]); end
    tests++; if (busy_cnt !== 1) begin fails++; $display("FAIL ic_cnt1 got %0d want 1", busy_cnt); end
    cm_vld = 2'b01; cm_rd[0] = 5; cm_tag[0] = 3; cm_data[0] = 32'hAA; #1;
    tests++; if (rd_busy[0] !== 0 || rd_data[0] !== 32'hAA) begin fails++; $display("FAIL ic_bypass got busy=%b data=%h want 0/aa", rd_busy[0], rd_data[0]); end
    tick(); idle(); #1;
    tests++; if (busy_cnt !== 0) begin fails++; $display("FAIL ic_cnt0 got %0d want 0", busy_cnt); end
    tests++; if (rd_busy[0] !== 0 || rd_data[0] !== 32'hAA) begin fails++; $display("FAIL ic_stored got busy=%b data=%h want 0/aa", rd_busy[0], rd_data[0]); end
  endtask

  task automatic test_stale_tag();
    issue(7, 2);
    issue(7, 9);
    rd_addr[1] = 7;
    cm_vld = 2'b10; cm_rd[1] = 7; cm_tag[1] = 2; cm_data[1] = 32'h11; #1;
    tests++; if (rd_busy[1] !== 1) begin fails++; $display("FAIL stale_nobypass got busy=%b want 1", rd_busy[1]); end
    tick(); idle(); #1;
    tests++; if (rd_busy[1] !== 1 || rd_tag[1] !== 9) begin fails++; $display("FAIL stale_kept got busy=%b tag=%0d want 1/9", rd_busy[1], rd_tag[1]); end
    cm_vld = 2'b01; cm_rd[0] = 7; cm_tag[0] = 9; cm_data[0] = 32'h22; #1;
    tests++; if (rd_busy[1] !== 0 || rd_data[1] !== 32'h22) begin fails++; $display("FAIL stale_bypass got busy=%b data=%h want 0/22", rd_busy[1], rd_data[1]); end
    tick(); idle(); #1;
    tests++; if (rd_busy[1] !== 0 || rd_data[1] !== 32'h22) begin fails++; $display("FAIL stale_final got busy=%b data=%h want 0/22", rd_busy[1], rd_data[1]); end
  endtask

  task automatic test_priority();
    issue(4, 1);
    iss_vld = 1; iss_rd = 4; iss_tag = 6;
    cm_vld = 2'b01; cm_rd[0] = 4; cm_tag[0] = 1; cm_data[0] = 32'h44;
    rd_addr[0] = 4; #1;
    tests++; if (rd_busy[0] !== 0 || rd_data[0] !== 32'h44) begin fails++; $display("FAIL pri_issue_nobypass got busy=%b data=%h want 0/44", rd_busy[0], rd_data[0]); end
    tick(); idle(); #1;
    tests++; if (rd_busy[0] !== 1 || rd_tag[0] !== 6) begin fails++; $display("FAIL pri_issue_wins got busy=%b tag=%0d want 1/6", rd_busy[0], rd_tag[0]); end
    cm_vld = 2'b11; cm_rd[0] = 8; cm_rd[1] = 8; cm_data[0] = 32'h80; cm_data[1] = 32'h81;
    tick(); idle(); rd_addr[1] = 8; #1;
    tests++; if (rd_data[1] !== 32'h81) begin fails++; $display("FAIL pri_port1_data got %h want 81", rd_data[1]); end
    issue(10, 5);
    cm_vld = 2'b11; cm_rd[0] = 10; cm_rd[1] = 10; cm_tag[0] = 5; cm_tag[1] = 5;
    cm_data[0] = 32'hA0; cm_data[1] = 32'hA1; rd_addr[0] = 10; #1;
    tests++; if (rd_busy[0] !== 0 || rd_data[0] !== 32'hA1) begin fails++; $display("FAIL pri_bypass_hi got busy=%b data=%h want 0/a1", rd_busy[0], rd_data[0]); end
    tick(); idle(); #1;
    tests++; if (busy_cnt !== 1) begin fails++; $display("FAIL pri_cnt got %0d want 1", busy_cnt); end
  endtask

  task automatic test_flush_x0();
    issue(1, 1); issue(2, 2); issue(3, 3);
    tests++; if (busy_cnt !== 4) begin fails++; $display("FAIL fl_cnt_pre got %0d want 4", busy_cnt); end
    flush_in = 1; iss_vld = 1; iss_rd = 9; iss_tag = 7;
    tick(); idle();
    rd_addr[0] = 1; rd_addr[1] = 9; #1;
    tests++; if (rd_busy !== 2'b00) begin fails++; $display("FAIL fl_busy got %b want 00", rd_busy); end
    tests++; if (busy_cnt !== 0) begin fails++; $display("FAIL fl_cnt got %0d want 0", busy_cnt); end
    iss_vld = 1; iss_rd = 0; iss_tag = 4;
    cm_vld = 2'b01; cm_rd[0] = 0; cm_tag[0] = 4; cm_data[0] = 32'hFF;
    tick(); idle(); rd_addr[0] = 0; #1;
    tests++; if (rd_busy[0] !== 0 || rd_data[0] !== 0 || rd_tag[0] !== 0) begin fails++; $display("FAIL x0 got busy=%b data=%h tag=%0d want 0/0/0", rd_busy[0], rd_data[0], rd_tag[0]); end
    tests++; if (busy_cnt !== 0) begin fails++; $display("FAIL x0_cnt got %0d want 0", busy_cnt); end
  endtask

  task automatic test_stall_reset();
    rdy_in = 0;
    iss_vld = 1; iss_rd = 12; iss_tag = 7;
    cm_vld = 2'b01; cm_rd[0] = 8; cm_data[0] = 32'h99;
    rd_addr[0] = 12; rd_addr[1] = 8;
    tick(); idle(); #1;
    tests++; if (rd_busy[0] !== 0 || busy_cnt !== 0) begin fails++; $display("FAIL stall_issue got busy=%b cnt=%0d want 0/0", rd_busy[0], busy_cnt); end
    tests++; if (rd_data[1] !== 32'h81) begin fails++; $display("FAIL stall_commit got %h want 81", rd_data[1]); end
    rdy_in = 1;
    issue(12, 7);
    tests++; if (busy_cnt !== 1) begin fails++; $display("FAIL stall_resume got %0d want 1", busy_cnt); end
    #2 rst_n_in = 0; #1;
    tests++; if (busy_cnt !== 0 || rd_busy[0] !== 0 || rd_data[1] !== 0) begin fails++; $display("FAIL async_reset got cnt=%0d busy=%b data=%h want 0/0/0", busy_cnt, rd_busy[0], rd_data[1]); end
    @(negedge clk_in); rst_n_in = 1;
  endtask

  initial begin
    test_reset();
    test_issue_commit();
    test_stale_tag();
    test_priority();
    test_flush_x0();
    test_stall_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
